// File: rtl/mem_io_arbiter.sv
// Two-port arbiter that shares the data-memory / IO path between the CPU (port 0)
// and the UART loader (port 1), decodes memory vs IO and absorbs BRAM read latency.
module mem_io_arbiter #(
  parameter int MEM_LAT     = 1,
  parameter int LOADER_PRIO = 0
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        cpu_req_i,
  input  logic        cpu_we_i,
  input  logic [13:0] cpu_addr_i,
  input  logic [31:0] cpu_wdata_i,
  output logic        cpu_ack_o,
  output logic [31:0] cpu_rdata_o,
  input  logic        ld_req_i,
  input  logic        ld_we_i,
  input  logic [13:0] ld_addr_i,
  input  logic [31:0] ld_wdata_i,
  output logic        ld_ack_o,
  output logic [31:0] ld_rdata_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [13:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i,
  input  logic [15:0] io_rdata_i,
  output logic [31:0] io_wdata_o,
  output logic        switch_cs_o,
  output logic        tube_cs_o,
  output logic        busy_o,
  output logic [1:0]  dbg_state_o
);

  // Handshake: a requester raises req with stable we/addr/wdata and holds it until
  // its one-cycle ack; req still high in the IDLE cycle after ack is a new request.
  typedef enum logic [1:0] {IDLE = 2'd0, ACCESS = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

  localparam logic [1:0] LAST_WAIT = 2'(MEM_LAT - 1);

  state_t      state;
  logic        last_ld;
  logic        lat_ld;
  logic        lat_we;
  logic        lat_mem;
  logic        lat_sw;
  logic [1:0]  wait_cnt;

  logic        grant_ld;
  logic        sel_we;
  logic [13:0] sel_addr;
  logic [31:0] sel_wdata;
  logic        sel_io;
  logic        sel_sw;
  logic        sel_tube;
  logic        finish;
  logic [31:0] finish_data;

  always_comb begin
    grant_ld = ld_req_i;
    if (cpu_req_i && ld_req_i) begin
      grant_ld = (LOADER_PRIO != 0) ? 1'b1 : !last_ld;
    end
    sel_we    = grant_ld ? ld_we_i    : cpu_we_i;
    sel_addr  = grant_ld ? ld_addr_i  : cpu_addr_i;
    sel_wdata = grant_ld ? ld_wdata_i : cpu_wdata_i;
    sel_io    = (sel_addr[13:8] == 6'h3F);
    // Switch is read-only and tube is write-only; anything else in IO space is a no-op.
    sel_sw    = sel_io && (sel_addr[7:4] == 4'h6) && !sel_we;
    sel_tube  = sel_io && (sel_addr[7:4] == 4'h7) && sel_we;
  end

  always_comb begin
    finish      = 1'b0;
    finish_data = 32'h0;
    if (state == ACCESS && !(lat_mem && !lat_we)) begin
      finish      = 1'b1;
      finish_data = lat_sw ? {{16{io_rdata_i[15]}}, io_rdata_i} : 32'h0;
    end else if (state == WAIT && wait_cnt == LAST_WAIT) begin
      finish      = 1'b1;
      finish_data = mem_rdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state       <= IDLE;
      last_ld     <= 1'b1;
      lat_ld      <= 1'b0;
      lat_we      <= 1'b0;
      lat_mem     <= 1'b0;
      lat_sw      <= 1'b0;
      wait_cnt    <= 2'd0;
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= 14'h0;
      mem_wdata_o <= 32'h0;
      io_wdata_o  <= 32'h0;
      switch_cs_o <= 1'b0;
      tube_cs_o   <= 1'b0;
      cpu_ack_o   <= 1'b0;
      ld_ack_o    <= 1'b0;
      cpu_rdata_o <= 32'h0;
      ld_rdata_o  <= 32'h0;
    end else begin
      mem_en_o    <= 1'b0;
      mem_we_o    <= 1'b0;
      switch_cs_o <= 1'b0;
      tube_cs_o   <= 1'b0;
      cpu_ack_o   <= 1'b0;
      ld_ack_o    <= 1'b0;
      cpu_rdata_o <= 32'h0;
      ld_rdata_o  <= 32'h0;
      case (state)
        IDLE: begin
          if (cpu_req_i || ld_req_i) begin
            state   <= ACCESS;
            last_ld <= grant_ld;
            lat_ld  <= grant_ld;
            lat_we  <= sel_we;
            lat_mem <= !sel_io;
            lat_sw  <= sel_sw;
            // Strobes are set here so they are high exactly during ACCESS.
            if (!sel_io) begin
              mem_en_o    <= 1'b1;
              mem_we_o    <= sel_we;
              mem_addr_o  <= sel_addr;
              mem_wdata_o <= sel_wdata;
            end else begin
              switch_cs_o <= sel_sw;
              tube_cs_o   <= sel_tube;
              io_wdata_o  <= sel_wdata;
            end
          end
        end
        ACCESS: begin
          if (lat_mem && !lat_we) begin
            state    <= WAIT;
            wait_cnt <= 2'd0;
          end else begin
            state <= RESP;
          end
        end
        WAIT: begin
          if (wait_cnt == LAST_WAIT) begin
            state <= RESP;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (finish) begin
        cpu_ack_o   <= !lat_ld;
        ld_ack_o    <= lat_ld;
        cpu_rdata_o <= lat_ld ? 32'h0 : finish_data;
        ld_rdata_o  <= lat_ld ? finish_data : 32'h0;
      end
    end
  end

  assign busy_o      = (state != IDLE);
  assign dbg_state_o = state;

endmodule

// File: tb/tb_mem_io_arbiter.sv
// Bench for mem_io_arbiter: dut 0 uses MEM_LAT=1 round-robin, dut 1 uses MEM_LAT=3
// with loader priority. Expected acks and strobes are queued and popped by a monitor.
module tb_mem_io_arbiter;

  logic        clk;
  logic        rst_n     [2];
  logic        req       [2][2];
  logic        we        [2][2];
  logic [13:0] addr      [2][2];
  logic [31:0] wdata     [2][2];
  logic        ack       [2][2];
  logic [31:0] rdata     [2][2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [13:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic [15:0] io_rdata  [2];
  logic [31:0] io_wdata  [2];
  logic        sw_cs     [2];
  logic        tube_cs   [2];
  logic        busy      [2];
  logic [1:0]  dbg_state [2];

  logic [31:0] bram [2][16384];
  logic [31:0] pipe [2][3];

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;

  // {dut, port, cycle[15:0], rdata}
  logic [49:0] exp_q[$];
  // {dut, cycle[15:0], en, we, sw, tube, mem_addr, data}
  logic [66:0] stb_q[$];
  logic [49:0] mon_e, mon_g;
  logic [66:0] mon_se, mon_sg;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_io_arbiter #(
      .MEM_LAT     (g == 0 ? 1 : 3),
      .LOADER_PRIO (g == 0 ? 0 : 1)
    ) u_dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n[g]),
      .cpu_req_i   (req[g][0]),
      .cpu_we_i    (we[g][0]),
      .cpu_addr_i  (addr[g][0]),
      .cpu_wdata_i (wdata[g][0]),
      .cpu_ack_o   (ack[g][0]),
      .cpu_rdata_o (rdata[g][0]),
      .ld_req_i    (req[g][1]),
      .ld_we_i     (we[g][1]),
      .ld_addr_i   (addr[g][1]),
      .ld_wdata_i  (wdata[g][1]),
      .ld_ack_o    (ack[g][1]),
      .ld_rdata_o  (rdata[g][1]),
      .mem_en_o    (mem_en[g]),
      .mem_we_o    (mem_we[g]),
      .mem_addr_o  (mem_addr[g]),
      .mem_wdata_o (mem_wdata[g]),
      .mem_rdata_i (mem_rdata[g]),
      .io_rdata_i  (io_rdata[g]),
      .io_wdata_o  (io_wdata[g]),
      .switch_cs_o (sw_cs[g]),
      .tube_cs_o   (tube_cs[g]),
      .busy_o      (busy[g]),
      .dbg_state_o (dbg_state[g])
    );
  end

  // Clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // BRAM models: data appears one cycle after the enable edge, then ripples down a pipe
  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (mem_en[d] && mem_we[d]) bram[d][mem_addr[d]] <= mem_wdata[d];
      if (mem_en[d] && !mem_we[d]) pipe[d][0] <= bram[d][mem_addr[d]];
      pipe[d][1] <= pipe[d][0];
      pipe[d][2] <= pipe[d][1];
    end
  end
  assign mem_rdata[0] = pipe[0][0];
  assign mem_rdata[1] = pipe[1][2];

  // Monitor / scoreboard
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (ack[d][p]) begin
          n_cmp++;
          mon_g = {d[0], p[0], cyc[15:0], rdata[d][p]};
          if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL ack_unexpected dut%0d port%0d: got ack at cyc %0d data %h, expected none",
                     d, p, cyc, rdata[d][p]);
          end else begin
            mon_e = exp_q.pop_front();
            if (mon_g !== mon_e) begin
              n_err++;
              $display("FAIL ack dut%0d: got port%0d cyc %0d data %h, expected port%0d dut%0d cyc %0d data %h",
                       d, p, cyc[15:0], rdata[d][p], mon_e[48], mon_e[49], mon_e[47:32], mon_e[31:0]);
            end
          end
        end
      end
      if (mem_en[d] || mem_we[d] || sw_cs[d] || tube_cs[d]) begin
        n_cmp++;
        mon_sg = {d[0], cyc[15:0], mem_en[d], mem_we[d], sw_cs[d], tube_cs[d],
                  mem_en[d] ? mem_addr[d] : 14'h0, mem_en[d] ? mem_wdata[d] : io_wdata[d]};
        if (stb_q.size() == 0) begin
          n_err++;
          $display("FAIL strobe_unexpected dut%0d: got strobe %h at cyc %0d, expected none", d, mon_sg[49:46], cyc);
        end else begin
          mon_se = stb_q.pop_front();
          if (mon_sg !== mon_se) begin
            n_err++;
            $display("FAIL strobe dut%0d: got %h, expected %h", d, mon_sg, mon_se);
          end
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic push_ack(input int d, input int p, input int c, input logic [31:0] data);
    exp_q.push_back({d[0], p[0], c[15:0], data});
  endtask

  task automatic push_stb(input int d, input int c, input logic en, input logic w, input logic sw,
                          input logic tb, input logic [13:0] a, input logic [31:0] data);
    stb_q.push_back({d[0], c[15:0], en, w, sw, tb, a, data});
  endtask

  // Driver: raise req, hold until ack (bounded), drop req
  task automatic drive(input int d, input int p, input logic w, input logic [13:0] a,
                       input logic [31:0] wd);
    int n;
    req[d][p] = 1'b1;
    we[d][p] = w;
    addr[d][p] = a;
    wdata[d][p] = wd;
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ack[d][p] && n < 30);
    n_cmp++;
    if (!ack[d][p]) begin
      n_err++;
      $display("FAIL ack_timeout dut%0d port%0d: got no ack in 30 cycles, expected ack", d, p);
    end
    req[d][p] = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no end of test by 100000, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c;
    for (int d = 0; d < 2; d++) begin
      rst_n[d] = 1'b0;
      for (int p = 0; p < 2; p++) begin
        req[d][p] = 1'b0;
        we[d][p] = 1'b0;
        addr[d][p] = 14'h0;
        wdata[d][p] = 32'h0;
      end
    end
    io_rdata[0] = 16'h8001;
    io_rdata[1] = 16'h0000;
    tick(2);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("rst_busy_d%0d", d), {31'h0, busy[d]}, 32'h0);
      check($sformatf("rst_state_d%0d", d), {30'h0, dbg_state[d]}, 32'h0);
      check($sformatf("rst_strobes_d%0d", d), {28'h0, mem_en[d], mem_we[d], sw_cs[d], tube_cs[d]}, 32'h0);
      check($sformatf("rst_mem_addr_d%0d", d), {18'h0, mem_addr[d]}, 32'h0);
      check($sformatf("rst_io_wdata_d%0d", d), io_wdata[d], 32'h0);
      check($sformatf("rst_acks_d%0d", d), {30'h0, ack[d][0], ack[d][1]}, 32'h0);
      check($sformatf("rst_rdata_d%0d", d), rdata[d][0] | rdata[d][1], 32'h0);
    end
    rst_n[0] = 1'b1;
    rst_n[1] = 1'b1;
    tick(2);

    // Memory write then read back, MEM_LAT = 1
    c = cyc;
    push_stb(0, c + 1, 1, 1, 0, 0, 14'h0010, 32'hDEADBEEF);
    push_ack(0, 0, c + 2, 32'h0);
    drive(0, 0, 1'b1, 14'h0010, 32'hDEADBEEF);
    tick(1);
    c = cyc;
    push_stb(0, c + 1, 1, 0, 0, 0, 14'h0010, 32'h0);
    push_ack(0, 0, c + 3, 32'hDEADBEEF);
    drive(0, 0, 1'b0, 14'h0010, 32'h0);
    check("mem_addr_hold", {18'h0, mem_addr[0]}, 32'h0000_0010);

    // Switch read (sign-extended), tube write, loader switch read
    tick(1);
    c = cyc;
    push_stb(0, c + 1, 0, 0, 1, 0, 14'h0, 32'h0);
    push_ack(0, 0, c + 2, 32'hFFFF8001);
    drive(0, 0, 1'b0, 14'h3F60, 32'h0);
    tick(1);
    c = cyc;
    push_stb(0, c + 1, 0, 0, 0, 1, 14'h0, 32'h0000_1234);
    push_ack(0, 0, c + 2, 32'h0);
    drive(0, 0, 1'b1, 14'h3F70, 32'h0000_1234);
    check("io_wdata_hold", io_wdata[0], 32'h0000_1234);
    io_rdata[0] = 16'h1234;
    tick(1);
    c = cyc;
    push_stb(0, c + 1, 0, 0, 1, 0, 14'h0, 32'h0);
    push_ack(0, 1, c + 2, 32'h0000_1234);
    drive(0, 1, 1'b0, 14'h3F6A, 32'h0);

    // Unmapped IO read, write to the switch, read of the tube: no strobes, rdata 0
    io_rdata[0] = 16'hABCD;
    tick(1);
    c = cyc;
    push_ack(0, 0, c + 2, 32'h0);
    drive(0, 0, 1'b0, 14'h3F20, 32'h0);
    tick(1);
    c = cyc;
    push_ack(0, 0, c + 2, 32'h0);
    drive(0, 0, 1'b1, 14'h3F60, 32'h0000_0055);
    tick(1);
    c = cyc;
    push_ack(0, 1, c + 2, 32'h0);
    drive(0, 1, 1'b0, 14'h3F70, 32'h0);

    // Round-robin contention: CPU, loader, CPU, then loader alone
    tick(1);
    c = cyc;
    push_stb(0, c + 1, 1, 1, 0, 0, 14'h0100, 32'h1111_1111);
    push_ack(0, 0, c + 2, 32'h0);
    push_stb(0, c + 4, 1, 1, 0, 0, 14'h0101, 32'h2222_2222);
    push_ack(0, 1, c + 5, 32'h0);
    push_stb(0, c + 7, 1, 1, 0, 0, 14'h0102, 32'h3333_3333);
    push_ack(0, 0, c + 8, 32'h0);
    push_stb(0, c + 10, 1, 1, 0, 0, 14'h0103, 32'h4444_4444);
    push_ack(0, 1, c + 11, 32'h0);
    fork
      begin
        drive(0, 0, 1'b1, 14'h0100, 32'h1111_1111);
        drive(0, 0, 1'b1, 14'h0102, 32'h3333_3333);
      end
      begin
        drive(0, 1, 1'b1, 14'h0101, 32'h2222_2222);
        drive(0, 1, 1'b1, 14'h0103, 32'h4444_4444);
      end
    join
    tick(1);
    c = cyc;
    push_stb(0, c + 1, 1, 0, 0, 0, 14'h0102, 32'h0);
    push_ack(0, 1, c + 3, 32'h3333_3333);
    drive(0, 1, 1'b0, 14'h0102, 32'h0);
    tick(1);
    c = cyc;
    push_stb(0, c + 1, 1, 0, 0, 0, 14'h0101, 32'h0);
    push_ack(0, 0, c + 3, 32'h2222_2222);
    drive(0, 0, 1'b0, 14'h0101, 32'h0);

    // Loader priority: three back-to-back loader writes starve the CPU
    tick(1);
    c = cyc;
    push_stb(1, c + 1, 1, 1, 0, 0, 14'h0200, 32'hCAFE_F00D);
    push_ack(1, 1, c + 2, 32'h0);
    push_stb(1, c + 4, 1, 1, 0, 0, 14'h0201, 32'h0BAD_F00D);
    push_ack(1, 1, c + 5, 32'h0);
    push_stb(1, c + 7, 1, 1, 0, 0, 14'h0202, 32'h1234_5678);
    push_ack(1, 1, c + 8, 32'h0);
    push_stb(1, c + 10, 1, 1, 0, 0, 14'h0203, 32'h8765_4321);
    push_ack(1, 0, c + 11, 32'h0);
    fork
      drive(1, 0, 1'b1, 14'h0203, 32'h8765_4321);
      begin
        drive(1, 1, 1'b1, 14'h0200, 32'hCAFE_F00D);
        drive(1, 1, 1'b1, 14'h0201, 32'h0BAD_F00D);
        drive(1, 1, 1'b1, 14'h0202, 32'h1234_5678);
      end
    join
    tick(1);
    c = cyc;
    push_stb(1, c + 1, 1, 0, 0, 0, 14'h0201, 32'h0);
    push_ack(1, 0, c + 5, 32'h0BAD_F00D);
    drive(1, 0, 1'b0, 14'h0201, 32'h0);

    // Reset during WAIT of a MEM_LAT = 3 read: abandoned, then re-issued
    tick(1);
    c = cyc;
    push_stb(1, c + 1, 1, 0, 0, 0, 14'h0200, 32'h0);
    req[1][0] = 1'b1;
    we[1][0] = 1'b0;
    addr[1][0] = 14'h0200;
    wdata[1][0] = 32'h0;
    tick(3);
    check("pre_reset_state", {30'h0, dbg_state[1]}, 32'h2);
    rst_n[1] = 1'b0;
    #1;
    check("mid_rst_busy", {31'h0, busy[1]}, 32'h0);
    check("mid_rst_state", {30'h0, dbg_state[1]}, 32'h0);
    check("mid_rst_acks", {30'h0, ack[1][0], ack[1][1]}, 32'h0);
    check("mid_rst_mem_addr", {18'h0, mem_addr[1]}, 32'h0);
    req[1][0] = 1'b0;
    tick(3);
    rst_n[1] = 1'b1;
    tick(1);
    c = cyc;
    push_stb(1, c + 1, 1, 0, 0, 0, 14'h0200, 32'h0);
    push_ack(1, 0, c + 5, 32'hCAFE_F00D);
    drive(1, 0, 1'b0, 14'h0200, 32'h0);

    tick(3);
    check("ack_queue_drained", exp_q.size(), 32'h0);
    check("strobe_queue_drained", stb_q.size(), 32'h0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
